// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage with a single-entry skid buffer and an IF/ID
// pipeline register.
//
// The PC drives the instruction memory address directly. The PC advances
// only when a word is accepted (FETCH state with imem_ready=1) or when a
// redirect arrives. If decode stalls in the same cycle that a word is
// accepted, the word is parked in the skid buffer. The stage then sits in
// HOLD and does not request until decode frees up.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous active-high reset
//   imem_req     - fetch request (0 in HOLD and whenever reset=1)
//   imem_addr    - fetch address, always equal to the PC register
//   imem_rdata   - instruction word returned by memory
//   imem_ready   - imem_rdata is valid this cycle
//   stall        - decode cannot take a new instruction; IF/ID holds
//   redirect     - taken branch; flush and refetch from redirect_pc
//   redirect_pc  - branch target (low two bits ignored)
//   id_instr     - IF/ID instruction (0 for a bubble)
//   id_pc4       - IF/ID fetch address + 4
//   id_valid     - id_instr holds a real instruction
//   id_op        - id_instr[31:26], opcode field for decode
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [5:0]  id_op
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] id_instr_next, id_pc4_next;
  logic        id_valid_next;
  logic [31:0] skid_instr, skid_instr_next;
  logic [31:0] skid_pc4, skid_pc4_next;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // Reset suppresses the request combinationally so that nothing is issued
  // during a reset cycle, even while the state register still reads FETCH.
  assign imem_req  = (state == FETCH) && !reset;
  assign id_op     = id_instr[31:26];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: PC, IF/ID and skid buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      id_instr   <= 32'd0;
      id_pc4     <= 32'd0;
      id_valid   <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc4   <= 32'd0;
    end else begin
      pc         <= pc_next;
      id_instr   <= id_instr_next;
      id_pc4     <= id_pc4_next;
      id_valid   <= id_valid_next;
      skid_instr <= skid_instr_next;
      skid_pc4   <= skid_pc4_next;
    end
  end

  // Next-state logic. Redirect wins over everything except reset. It flushes
  // IF/ID to a bubble and drops both the parked word and any word returning
  // in the same cycle.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    id_instr_next   = id_instr;
    id_pc4_next     = id_pc4;
    id_valid_next   = id_valid;
    skid_instr_next = skid_instr;
    skid_pc4_next   = skid_pc4;

    if (redirect) begin
      pc_next         = {redirect_pc[31:2], 2'b00};
      id_instr_next   = 32'd0;
      id_valid_next   = 1'b0;
      skid_instr_next = 32'd0;
      skid_pc4_next   = 32'd0;
      state_next      = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc_next = pc_plus4;
            if (stall) begin
              skid_instr_next = imem_rdata;
              skid_pc4_next   = pc_plus4;
              state_next      = HOLD;
            end else begin
              id_instr_next = imem_rdata;
              id_pc4_next   = pc_plus4;
              id_valid_next = 1'b1;
            end
          end else if (!stall) begin
            // Memory has not answered yet; feed decode a NOP bubble.
            id_instr_next = 32'd0;
            id_valid_next = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_instr_next = skid_instr;
            id_pc4_next   = skid_pc4;
            id_valid_next = 1'b1;
            state_next    = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address; equals current PC.
REQ-006 imem_rdata  input  32  instruction word; valid when imem_ready=1.
REQ-007 imem_ready  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0.
REQ-008 stall  input  1  decode stage cannot accept a new instruction; IF/ID must hold.
REQ-009 redirect  input  1  taken branch resolved downstream; flush and refetch.
REQ-010 redirect_pc  input  32  branch target; bits [1:0] forced to 0 internally.
REQ-011 id_instr  output  32  IF/ID registered instruction.
REQ-012 id_pc4  output  32  IF/ID registered address of fetched instruction + 4.
REQ-013 id_valid  output  1  id_instr is a real instruction (0 = bubble).
REQ-014 id_op  output  6  id_instr[31:26]; drives op input of decode control unit.

Function
REQ-015 States: FETCH (imem_req=1) and HOLD (imem_req=0, one fetched word parked in skid buffer).
REQ-016 imem_addr SHALL equal PC register at all times; PC SHALL change only on acceptance or redirect, so address is stable while imem_req=1 and imem_ready=0.
REQ-017 Acceptance = FETCH and imem_ready=1; on acceptance PC <= PC+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-018 FETCH, accept, stall=0: id_instr<=imem_rdata, id_pc4<=PC+4, id_valid<=1; stay FETCH.
REQ-019 FETCH, accept, stall=1: IF/ID holds; skid buffer <= {imem_rdata, PC+4}; next state HOLD.
REQ-020 FETCH, no accept, stall=0: bubble -- id_instr<=0, id_valid<=0, id_pc4 holds.
REQ-021 FETCH, no accept, stall=1: IF/ID holds.
REQ-022 HOLD, stall=1: everything holds, imem_req=0.
REQ-023 HOLD, stall=0: IF/ID <= skid buffer with id_valid=1; next state FETCH (request reissued next cycle, at PC already advanced).
REQ-024 Fetch latency: instruction accepted in cycle N appears on id_* in cycle N+1 if stall=0 in N.
REQ-025 redirect=1 takes priority over stall and acceptance: PC<={redirect_pc[31:2],2'b00}; id_instr<=0, id_valid<=0; skid buffer discarded; same-cycle imem_rdata discarded; next state FETCH.
REQ-026 id_op SHALL be combinational from id_instr; bubble yields id_op=6'b000000 with id_instr=0 (sll $0 NOP, architecturally harmless).
REQ-027 Never more than one outstanding word: skid buffer depth 1; no request issued in HOLD.

Reset
REQ-028 While reset=1 at a clock edge: PC<=RESET_PC, state<=FETCH, id_instr<=0, id_pc4<=0, id_valid<=0, skid buffer cleared.
REQ-029 imem_req SHALL be 0 in any cycle where reset=1; reset overrides redirect, stall, imem_ready.
REQ-030 Reset asserted mid-HOLD or mid-wait SHALL drop the parked/pending word; first request after reset uses address RESET_PC.

Verification
REQ-031 Reset, then imem_ready=1 every cycle, stall=0, rdata=addr-tagged words -> imem_addr 0,4,8,...; id_pc4 4,8,12,... one cycle later; id_valid=1 continuous.
REQ-032 imem_ready low 3 cycles at addr 0x10 -> imem_addr held 0x10, three bubbles (id_valid=0, id_instr=0), then id_instr=word@0x10, id_pc4=0x14.
REQ-033 Accept at 0x20 with stall=1 for 2 cycles -> HOLD, imem_req=0, IF/ID unchanged; stall drops -> id_instr=word@0x20, id_pc4=0x24, next request at 0x24.
REQ-034 redirect=1, redirect_pc=0x103 while in HOLD with stall=1 -> next cycle imem_addr=0x100, id_valid=0, parked word never reaches id_instr.
REQ-035 PC=0xFFFF_FFFC accepted -> next imem_addr=0x0, id_pc4=0x0.
REQ-036 reset asserted while imem_req=1, imem_ready=0 -> next cycle all id_* zero, imem_addr=RESET_PC, no word delivered from old request.
